i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Single-byte I2C master bit engine.
- Consumes the command handshake driven by the package write/read tasks: newd strobe, op (0 = write, 1 = read), 7-bit addr, 8-bit data.
- Generates START, address+R/W, data byte, ACK/NACK and STOP on open-drain SCL/SDA.
- Returns read data and status to the testbench/system side.

Parameters:
- SYS_FREQ, 40_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz.
- QTR (localparam), SYS_FREQ/(4*I2C_FREQ), clocks per quarter bit period; elaboration error if QTR < 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- newd  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = write, 1 = read.
- addr  in  7  target slave address.
- din  in  8  write data byte.
- dout  out  8  read data byte; valid when done = 1 and op was read.
- busy  out  1  high from command accept until return to IDLE.
- done  out  1  one-cycle pulse on transaction end.
- ack_err  out  1  slave NACK seen on address or write-data ACK.
- scl_o  out  1  SCL drive; 1 = released/high, 0 = pull low.
- scl_i  in  1  sensed SCL line; used only with the optional feature.
- sda_oe  out  1  SDA pull-low enable; 1 = drive 0, 0 = release.
- sda_i  in  1  sensed SDA line.

Behaviour:
- Reset values, all applied on the next clk edge with rst = 1, including mid-transaction:
  - scl_o = 1, sda_oe = 0, busy = 0, done = 0, ack_err = 0, dout = 0.
  - FSM = IDLE, counters = 0.
  - No STOP is generated on reset.
- Accept:
  - In IDLE, newd = 1 latches op, addr, din and clears ack_err.
  - busy = 1 from the next cycle.
  - newd outside IDLE is ignored; no queuing.
- Bit timing:
  - Each bit slot = 4 quarters × QTR clocks.
  - q0: SCL low; SDA updated at q0 start.
  - q1, q2: SCL high; SDA sampled on the last clock of q2.
  - q3: SCL low.
- FSM states:
  - IDLE.
  - START: SDA released with SCL high for q0-q1, SDA low at q2, SCL low at q3.
  - ADDR: 8 bits, MSB first = {addr, op}.
  - ADDR_ACK: SDA released; sample.
  - WR_DATA: din MSB first.
  - WR_ACK: SDA released; sample.
  - RD_DATA: SDA released; shift sda_i in MSB first.
  - RD_NACK: master releases SDA (NACK, single byte).
  - STOP: SDA low q0-q1, SCL high from q1, SDA released at q2.
  - DONE: one cycle, then IDLE.
- Transitions:
  - ADDR_ACK with sample 1: set ack_err = 1, go to STOP.
  - ADDR_ACK with sample 0: op = 0 → WR_DATA; op = 1 → RD_DATA.
  - WR_ACK: sample 1 sets ack_err; always → STOP.
  - RD_NACK → STOP.
- Outputs at transaction end:
  - dout updated at the end of RD_DATA only; holds otherwise.
  - DONE state: done = 1 for exactly one cycle, busy = 0 in the same cycle.
  - ack_err holds until the next accept or reset.
- Latency: a full transaction = 20 bit slots (START 1, addr+ack 9, data+ack 9, STOP 1) = 80×QTR clocks from accept to the done cycle.
- Counters: quarter counter is ceil(log2(QTR)) bits, wraps QTR-1 → 0; 3-bit bit counter counts 7 → 0.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: on entry to q1 of any slot, the quarter counter holds at 0 while scl_o = 1 and scl_i = 0 (slave stretching); timing resumes once scl_i = 1. Latency grows by the stretch length.
- Undefined: scl_i is ignored and timing is fixed at 80×QTR.

Test Plan (QTR = 100):
- Write, ACKed: addr 0x50, din 0xA5, op 0, slave ACKs both → SDA bits 1010000_0 and 10100101 sampled on SCL highs; done pulses 8000 clocks after accept; ack_err = 0.
- Read: addr 0x3C, op 1, slave drives 0x5A → dout = 0x5A at done; master releases SDA in the 9th data slot (NACK); STOP seen.
- Address NACK: addr 0x22, sda_i = 1 in ADDR_ACK → no data slot; STOP follows; ack_err = 1; done pulses 4400 clocks after accept.
- newd pulsed while busy, with addr 0x11 → ignored; in-flight addr and data unchanged on the bus; only one done pulse.
- rst asserted mid-WR_DATA → next clk edge: scl_o = 1, sda_oe = 0, busy = 0; a subsequent newd starts a clean START.
- With I2C_CLK_STRETCH_EN: scl_i held low for 250 clocks at the addr bit 3 rise → done delayed by exactly 250 clocks (8250 total).

Source files
------------

// File: rtl/i2c_master_ctrl_if.sv
// Command handshake and open-drain SCL/SDA pins of the single-byte I2C master.
// The master modport faces the bit engine; the slave modport faces the system/bus side.
interface i2c_master_ctrl_if;
    logic       newd;
    logic       op;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_o;
    logic       scl_i;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        input  newd, op, addr, din, scl_i, sda_i,
        output dout, busy, done, ack_err, scl_o, sda_oe
    );

    modport slave (
        output newd, op, addr, din, scl_i, sda_i,
        input  dout, busy, done, ack_err, scl_o, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master bit engine: START, addr+R/W, one data byte, ACK/NACK, STOP.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | lines released, waiting for newd
// S_START    | SDA falls at q2 while SCL high, SCL low at q3
// S_ADDR     | 8 bits {addr, op}, MSB first
// S_ADDR_ACK | SDA released, slave ACK sampled
// S_WR_DATA  | din, MSB first
// S_WR_ACK   | SDA released, slave ACK sampled
// S_RD_DATA  | SDA released, slave bits shifted in MSB first
// S_RD_NACK  | master leaves SDA released (NACK, single byte)
// S_STOP     | SDA low q0-q1, SCL high from q1, SDA released q2
// S_DONE     | one-cycle done pulse, then IDLE
module i2c_master_ctrl #(
    parameter int SYS_FREQ = 40_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_ctrl_if.master bus
);
    localparam int QTR = SYS_FREQ / (4 * I2C_FREQ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

    if (QTR < 2) begin : g_bad_qtr
        $error("i2c_master_ctrl: QTR must be at least 2");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_NACK, S_STOP, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [2:0]    bitcnt;
    logic          op_r;
    logic [6:0]    addr_r;
    logic [7:0]    din_r;
    logic [7:0]    rx;
    logic          sda_s;
    logic          ack_err_r;
    logic [7:0]    dout_r;

    logic          q_end, slot_end, samp, stall;
    logic          scl_drv, sda_drv, mid;
    logic [7:0]    abyte;

    assign q_end    = (qcnt == QLAST);
    assign slot_end = q_end && (qtr == 2'd3);
    assign samp     = q_end && (qtr == 2'd2);
    assign mid      = qtr[0] ^ qtr[1];
    assign abyte    = {addr_r, op_r};

    // A stretching slave holds SCL low after we release it at q1 entry.
`ifdef I2C_CLK_STRETCH_EN
    assign stall = (qtr == 2'd1) && (qcnt == '0) && scl_drv && !bus.scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = bus.scl_i;
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        scl_drv = 1'b1;
        sda_drv = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.newd) state_n = S_START;
            end
            S_START: begin
                scl_drv = (qtr != 2'd3);
                sda_drv = qtr[1];
                if (slot_end) state_n = S_ADDR;
            end
            S_ADDR: begin
                scl_drv = mid;
                sda_drv = ~abyte[bitcnt];
                if (slot_end && bitcnt == 3'd0) state_n = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_drv = mid;
                if (slot_end) begin
                    if (sda_s)     state_n = S_STOP;
                    else if (op_r) state_n = S_RD_DATA;
                    else           state_n = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                scl_drv = mid;
                sda_drv = ~din_r[bitcnt];
                if (slot_end && bitcnt == 3'd0) state_n = S_WR_ACK;
            end
            S_WR_ACK: begin
                scl_drv = mid;
                if (slot_end) state_n = S_STOP;
            end
            S_RD_DATA: begin
                scl_drv = mid;
                if (slot_end && bitcnt == 3'd0) state_n = S_RD_NACK;
            end
            S_RD_NACK: begin
                scl_drv = mid;
                if (slot_end) state_n = S_STOP;
            end
            S_STOP: begin
                scl_drv = (qtr != 2'd0);
                sda_drv = !qtr[1];
                if (slot_end) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt      <= '0;
            qtr       <= 2'd0;
            bitcnt    <= 3'd0;
            op_r      <= 1'b0;
            addr_r    <= 7'd0;
            din_r     <= 8'd0;
            rx        <= 8'd0;
            sda_s     <= 1'b0;
            ack_err_r <= 1'b0;
            dout_r    <= 8'd0;
        end else if (state == S_IDLE) begin
            qcnt <= '0;
            qtr  <= 2'd0;
            if (bus.newd) begin
                op_r      <= bus.op;
                addr_r    <= bus.addr;
                din_r     <= bus.din;
                ack_err_r <= 1'b0;
                bitcnt    <= 3'd7;
            end
        end else if (state != S_DONE && !stall) begin
            if (q_end) begin
                qcnt <= '0;
                qtr  <= qtr + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
            if (samp) begin
                sda_s <= bus.sda_i;
                if (state == S_RD_DATA) rx <= {rx[6:0], bus.sda_i};
            end
            // bitcnt wraps 0 -> 7, which re-arms it for the next byte
            if (slot_end) begin
                if (state inside {S_ADDR, S_WR_DATA, S_RD_DATA}) bitcnt <= bitcnt - 3'd1;
                if ((state == S_ADDR_ACK || state == S_WR_ACK) && sda_s) ack_err_r <= 1'b1;
                if (state == S_RD_DATA && bitcnt == 3'd0) dout_r <= rx;
            end
        end
    end

    assign bus.scl_o   = scl_drv;
    assign bus.sda_oe  = sda_drv;
    assign bus.busy    = (state != S_IDLE) && (state != S_DONE);
    assign bus.done    = (state == S_DONE);
    assign bus.dout    = dout_r;
    assign bus.ack_err = ack_err_r;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: reactive slave on the open-drain lines plus a scoreboard of
// expected per-transaction results, popped and compared on each done pulse.
module tb_i2c_master_ctrl;
    localparam int QTR  = 100;
    localparam int SLOT = 4 * QTR;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STR_EXTRA = 250;
`else
    localparam int STR_EXTRA = 0;
`endif

    typedef struct {
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic [7:0] dout;
        logic       ack_err;
        logic       rd;
        logic       ack_a;
        int         lat;
        int         rises;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.SYS_FREQ(40_000_000), .I2C_FREQ(100_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic       sl_pull = 1'b0;
    logic       stretch = 1'b0;
    logic       str_arm = 1'b0;
    int         str_cnt = 0;
    logic       sl_ack_addr = 1'b1, sl_ack_data = 1'b1;
    logic [7:0] sl_rd_byte = 8'h00;
    logic [7:0] sl_abyte = 8'h00, sl_dbyte = 8'h00;
    logic       sl_mnack = 1'b0, sl_stopf = 1'b0;
    int         sl_rise = 0, n_start = 0, n_stop = 0;

    assign bus.sda_i = ~bus.sda_oe & ~sl_pull;
    assign bus.scl_i = bus.scl_o & ~stretch;

    exp_t       sb[$];
    int         n_chk = 0, n_bad = 0;
    int         cyc = 0, acc_cyc = 0;
    int         n_done = 0, n_exp_done = 0;
    logic [7:0] exp_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave model, stretch driver and done monitor share one process to keep ordering fixed.
    initial begin
        logic scl, sda, scl_p, sda_p, prev_done;
        exp_t e;
        scl_p = 1'b1; sda_p = 1'b1; prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (str_cnt > 0) begin
                str_cnt--;
                if (str_cnt == 0) stretch = 1'b0;
            end
            scl = bus.scl_o;
            sda = bus.sda_i;
            if (scl && scl_p && sda_p && !sda) begin
                n_start++;
                sl_rise = 0; sl_abyte = 8'h00; sl_dbyte = 8'h00; sl_pull = 1'b0; sl_stopf = 1'b0;
            end else if (scl && scl_p && !sda_p && sda) begin
                n_stop++;
                sl_stopf = 1'b1;
            end
            if (scl && !scl_p) begin
                if (sl_rise < 8)                      sl_abyte = {sl_abyte[6:0], sda};
                else if (sl_rise >= 9 && sl_rise < 17) sl_dbyte = {sl_dbyte[6:0], sda};
                else if (sl_rise == 17)               sl_mnack = sda;
                sl_rise++;
                if (str_arm && sl_rise == 4) begin
                    stretch = 1'b1; str_cnt = 250; str_arm = 1'b0;
                end
            end
            if (!scl && scl_p) begin
                sl_pull = 1'b0;
                if (sl_rise == 8)
                    sl_pull = sl_ack_addr;
                else if (sl_rise >= 9 && sl_rise <= 16 && sl_abyte[0] && sl_ack_addr)
                    sl_pull = ~sl_rd_byte[16 - sl_rise];
                else if (sl_rise == 17 && !sl_abyte[0])
                    sl_pull = sl_ack_data;
            end
            scl_p = scl;
            sda_p = sda;

            if (prev_done) chk("done_pulse", bus.done, 1'b0);
            prev_done = bus.done;
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("done_unexpected", n_done, n_exp_done);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("ack_err", bus.ack_err, e.ack_err);
                    chk("busy_at_done", bus.busy, 1'b0);
                    chk("addr_byte", sl_abyte, e.abyte);
                    chk("scl_rises", sl_rise, e.rises);
                    chk("stop_seen", sl_stopf, 1'b1);
                    chk("dout", bus.dout, e.dout);
                    if (e.ack_a && !e.rd) chk("wr_byte", sl_dbyte, e.dbyte);
                    if (e.ack_a && e.rd)  chk("rd_nack", sl_mnack, 1'b1);
                end
            end
        end
    end

    task automatic xact(input logic o, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input logic ack_a, input logic ack_d,
                        input logic arm);
        exp_t e;
        sl_ack_addr = ack_a;
        sl_ack_data = ack_d;
        sl_rd_byte  = rd;
        str_arm     = arm;
        if (o && ack_a) exp_dout = rd;
        e.abyte   = {a, o};
        e.dbyte   = d;
        e.dout    = exp_dout;
        e.ack_err = !ack_a || (!o && !ack_d);
        e.rd      = o;
        e.ack_a   = ack_a;
        e.lat     = (ack_a ? 80 * QTR : 44 * QTR) + (arm ? STR_EXTRA : 0);
        e.rises   = ack_a ? 19 : 10;
        sb.push_back(e);
        n_exp_done++;
        @(negedge clk);
        bus.newd = 1'b1; bus.op = o; bus.addr = a; bus.din = d;
        @(posedge clk);
        acc_cyc = cyc + 1;
        @(negedge clk);
        bus.newd = 1'b0;
        chk("busy_after_accept", bus.busy, 1'b1);
    endtask

    task automatic wait_empty();
        int i = 0;
        while (sb.size() != 0 && i < 12000) begin
            @(posedge clk);
            i++;
        end
        chk("wait_timeout", sb.size(), 0);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int s0, p0;
        rst = 1'b1;
        bus.newd = 1'b0; bus.op = 1'b0; bus.addr = 7'h00; bus.din = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_scl_o", bus.scl_o, 1'b1);
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ack_err", bus.ack_err, 1'b0);
        chk("rst_dout", bus.dout, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        xact(1'b0, 7'h50, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0);
        wait_empty();
        xact(1'b1, 7'h3C, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b0);
        wait_empty();
        xact(1'b0, 7'h22, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_empty();
        chk("ack_err_hold", bus.ack_err, 1'b1);
        chk("dout_hold", bus.dout, exp_dout);

        // newd while busy must not disturb the in-flight transfer
        xact(1'b0, 7'h2B, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (3000) @(posedge clk);
        @(negedge clk);
        bus.newd = 1'b1; bus.op = 1'b1; bus.addr = 7'h11; bus.din = 8'hFF;
        @(negedge clk);
        bus.newd = 1'b0;
        wait_empty();

        xact(1'b0, 7'h41, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
        wait_empty();

        // reset in the middle of WR_DATA (data slot 2, SCL low)
        xact(1'b0, 7'h33, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (12 * SLOT + 50) @(posedge clk);
        p0 = n_stop;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_scl_o", bus.scl_o, 1'b1);
        chk("midrst_sda_oe", bus.sda_oe, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_dout", bus.dout, 8'h00);
        void'(sb.pop_back());
        n_exp_done--;
        exp_dout = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        chk("no_stop_on_rst", n_stop, p0);

        s0 = n_start;
        xact(1'b0, 7'h50, 8'h96, 8'h00, 1'b1, 1'b1, 1'b0);
        wait_empty();
        chk("start_after_rst", n_start - s0, 1);

        xact(1'b0, 7'h5D, 8'h69, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_empty();

        repeat (2 * SLOT) @(posedge clk);
        chk("done_count", n_done, n_exp_done);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
